// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter moving one 6-bit operand per cycle from eight requesters onto a shared bus.
// Define OPERAND_BUS_ARBITER_TIMEOUT_EN to drop operands stalled for 255 cycles.
module operand_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  req,
  input  logic [47:0] data_in,
  input  logic        out_ready,
  output logic [2:0]  selector,
  output logic [5:0]  data_out,
  output logic        out_valid,
  output logic [7:0]  grant,
  output logic        timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_last;
  logic [2:0]  r_selector;
  logic [5:0]  r_dataOut;
  logic        w_release;
  logic        w_timeout;
  logic        w_found;
  logic [7:0]  w_grant;
  logic [7:0]  w_mask;
  logic [2:0]  w_pick;
  logic [2:0]  w_cand;
  logic [5:0]  w_pickData;

`ifdef OPERAND_BUS_ARBITER_TIMEOUT_EN
  logic [7:0] r_stall;

  // The 255th stalled cycle is the one whose increment takes the counter to 255.
  assign w_timeout = (r_state == BUSY) && !out_ready && (r_stall == 8'd254);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall <= 8'd0;
    end else if ((r_state == BUSY) && !out_ready && !w_timeout) begin
      r_stall <= r_stall + 8'd1;
    end else begin
      r_stall <= 8'd0;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_release = (r_state == BUSY) && (out_ready || w_timeout);
  assign w_grant   = w_release ? (8'b1 << r_selector) : 8'b0;

  // The slot just granted is masked out so a held request cannot win twice in a row.
  always_comb begin
    w_mask = 8'b0;
    if (r_state == IDLE) begin
      w_mask = req;
    end else if (w_release) begin
      w_mask = req & ~w_grant;
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = 3'd0;
    w_cand  = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      w_cand = r_last + k[2:0];
      if (!w_found && w_mask[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_pickData = 6'd0;
    for (int s = 0; s < 8; s++) begin
      if (w_pick == s[2:0]) begin
        w_pickData = data_in[s*6 +: 6];
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    if ((r_state == BUSY) && !w_release) begin
      w_nextState = BUSY;
    end else if (w_found) begin
      w_nextState = BUSY;
    end else begin
      w_nextState = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_selector <= 3'd0;
      r_dataOut  <= 6'd0;
      r_last     <= 3'd7;
    end else if (w_found) begin
      r_selector <= w_pick;
      r_dataOut  <= w_pickData;
      r_last     <= w_pick;
    end
  end

  assign selector  = r_selector;
  assign data_out  = r_dataOut;
  assign out_valid = (r_state == BUSY);
  assign grant     = w_grant;
  assign timeout   = w_timeout;

endmodule
